// File: rtl/sha256_multiblock_core.sv
// Iterative SHA-256/SHA-224 compression core for pre-padded 512-bit blocks.
// The chaining value carries across blocks; UNROLL rounds are evaluated per clock.
module sha256_multiblock_core #(
  parameter int UNROLL = 1,
  parameter int SHA224 = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_first,
  input  logic [511:0] blk_data,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_multiblock_core: UNROLL must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;
  typedef logic [0:7][31:0]  hvec_t;
  typedef logic [0:15][31:0] wwin_t;

  localparam hvec_t IV = (SHA224 != 0) ?
    hvec_t'(256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4) :
    hvec_t'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);

  localparam logic [5:0] CNT_STEP = 6'(UNROLL);
  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  wwin_t          w_q, w_d;
  hvec_t          wv_q, wv_d;
  hvec_t          h_base_q, h_base_d;
  hvec_t          h_chain_q, h_chain_d;
  logic [255:0]   digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;

  hvec_t          wv_rnd;
  wwin_t          w_rnd;
  hvec_t          base;
  logic [31:0]    t1, t2;
  logic [5:0]     k_idx;

  // UNROLL chained rounds; w_rnd[0] is always W[t] for the round being applied.
  always_comb begin
    wv_rnd = wv_q;
    w_rnd  = w_q;
    t1     = '0;
    t2     = '0;
    k_idx  = cnt_q;
    for (int j = 0; j < UNROLL; j++) begin
      k_idx  = cnt_q + 6'(j);
      t1     = wv_rnd[7] + bsig1(wv_rnd[4]) + ((wv_rnd[4] & wv_rnd[5]) ^ (~wv_rnd[4] & wv_rnd[6]))
             + K_TAB[k_idx] + w_rnd[0];
      t2     = bsig0(wv_rnd[0])
             + ((wv_rnd[0] & wv_rnd[1]) ^ (wv_rnd[0] & wv_rnd[2]) ^ (wv_rnd[1] & wv_rnd[2]));
      wv_rnd = {t1 + t2, wv_rnd[0:2], wv_rnd[3] + t1, wv_rnd[4:6]};
      w_rnd  = {w_rnd[1:15], ssig1(w_rnd[14]) + w_rnd[9] + ssig0(w_rnd[1]) + w_rnd[0]};
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    w_d            = w_q;
    wv_d           = wv_q;
    h_base_d       = h_base_q;
    h_chain_d      = h_chain_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    base           = h_chain_q;
    unique case (state_q)
      S_IDLE: begin
        if (blk_valid && blk_ready) begin
          base     = blk_first ? IV : h_chain_q;
          w_d      = blk_data;
          wv_d     = base;
          h_base_d = base;
          cnt_d    = '0;
          state_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d  = wv_rnd;
        w_d   = w_rnd;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_chain_d[i] = h_base_q[i] + wv_q[i];
        digest_d = h_chain_d;
        if (SHA224 != 0) digest_d[31:0] = '0;
        digest_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the W window and working registers are reset too, so an aborted block leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      w_q            <= '0;
      wv_q           <= '0;
      h_base_q       <= '0;
      h_chain_q      <= IV;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      w_q            <= w_d;
      wv_q           <= wv_d;
      h_base_q       <= h_base_d;
      h_chain_q      <= h_chain_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign blk_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Self-checking bench: five core instances (UNROLL 1/2/4/8, plus SHA-224) against
// a straightforward message-schedule SHA-256 model and known-answer digests.
module tb_sha256_multiblock_core;

  localparam int N_DUT = 5;

  localparam logic [255:0] IV256   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224   = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] ABC256  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC224  = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] TWO_BLK = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bv [N_DUT];
  logic         br [N_DUT];
  logic         bf [N_DUT];
  logic [511:0] bd [N_DUT];
  logic         dv [N_DUT];
  logic [255:0] dg [N_DUT];
  logic         bz [N_DUT];

  logic [255:0] chain [N_DUT];
  int           vec_cnt = 0;
  int           miscompare_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    sha256_multiblock_core #(
      .UNROLL((g < 4) ? (1 << g) : 1),
      .SHA224((g == 4) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .blk_valid   (bv[g]),
      .blk_ready   (br[g]),
      .blk_first   (bf[g]),
      .blk_data    (bd[g]),
      .digest_valid(dv[g]),
      .digest      (dg[g]),
      .busy        (bz[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unroll_of(input int idx);
    return (idx < 4) ? (1 << idx) : 1;
  endfunction

  function automatic logic [255:0] iv_of(input int idx);
    return (idx == 4) ? IV224 : IV256;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-entry schedule expanded up front, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] model_step(input int idx, input logic [511:0] data, input logic first);
    logic [255:0] r;
    r = compress(first ? iv_of(idx) : chain[idx], data);
    chain[idx] = r;
    if (idx == 4) r[31:0] = '0;
    return r;
  endfunction

  task automatic rand_block(output logic [511:0] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
  endtask

  // Offer one block, then watch 64/UNROLL+4 cycles: latency, ready/busy/valid profile, digest hold.
  task automatic run_block(input int idx, input logic [511:0] data, input logic first,
                           input bit hold, input logic [255:0] exp_d, input string tag);
    int           lat, prof_bad, len;
    bit           acc;
    logic [255:0] prev, got;
    logic [511:0] junk;
    len = 64 / unroll_of(idx) + 2;
    @(negedge clk);
    bv[idx] = 1'b1; bd[idx] = data; bf[idx] = first;
    acc = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (br[idx]) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc) begin
      check({tag, "_accept"}, 0, 1);
      bv[idx] = 1'b0;
      return;
    end
    prev = dg[idx];
    got  = '0;
    @(posedge clk);
    lat = 0; prof_bad = 0;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      if (dv[idx]) begin
        if (lat == 0) lat = k;
        if (k != len) prof_bad++;
      end
      if (k <= len) begin
        if (br[idx] !== (k == len)) prof_bad++;
        if (bz[idx] !== (k < len)) prof_bad++;
      end
      if (k < len && dg[idx] !== prev) prof_bad++;
      if (k == len) got = dg[idx];
      if (k > len && dg[idx] !== got) prof_bad++;
      if (hold && k < len) begin
        rand_block(junk);
        bd[idx] = junk;
        bf[idx] = 1'($urandom_range(0, 1));
      end else begin
        bv[idx] = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, len);
    check({tag, "_profile"}, prof_bad, 0);
    check({tag, "_digest"}, got, exp_d);
  endtask

  initial begin
    logic [511:0] abc, b1, b2, rb;
    logic [255:0] e;
    logic         f;
    int           idx, pulses;

    for (int i = 0; i < N_DUT; i++) begin
      bv[i] = 1'b0; bf[i] = 1'b0; bd[i] = '0; chain[i] = iv_of(i);
    end
    abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 14; i++)
      b1[511 - 32*i -: 32] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
    b1[63:0] = {32'h80000000, 32'h00000000};
    b2 = {480'h0, 32'h000001c0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("rst_ready%0d", i), br[i], 1);
      check($sformatf("rst_valid%0d", i), dv[i], 0);
      check($sformatf("rst_busy%0d", i), bz[i], 0);
      check($sformatf("rst_digest%0d", i), dg[i], 0);
    end
    rst_n = 1'b1;

    e = model_step(0, abc, 1'b1);
    run_block(0, abc, 1'b1, 1'b0, ABC256, "abc_u1");

    for (int i = 0; i < 4; i++) begin
      e = model_step(i, b1, 1'b1);
      run_block(i, b1, 1'b1, 1'b0, e, $sformatf("two_blk1_u%0d", unroll_of(i)));
      e = model_step(i, b2, 1'b0);
      run_block(i, b2, 1'b0, 1'b0, TWO_BLK, $sformatf("two_blk2_u%0d", unroll_of(i)));
    end

    e = model_step(4, abc, 1'b1);
    run_block(4, abc, 1'b1, 1'b0, ABC224, "abc_224");

    e = model_step(0, abc, 1'b1);
    run_block(0, abc, 1'b1, 1'b0, ABC256, "abc_again");
    e = model_step(0, abc, 1'b0);
    run_block(0, abc, 1'b0, 1'b0, e, "abc_chained");
    check("chain_differs", 256'(dg[0] != ABC256), 1);

    e = model_step(0, abc, 1'b1);
    run_block(0, abc, 1'b1, 1'b1, ABC256, "abc_hold");

    for (int r = 0; r < 15; r++) begin
      idx = r % N_DUT;
      rand_block(rb);
      f = 1'($urandom_range(0, 1));
      e = model_step(idx, rb, f);
      run_block(idx, rb, f, bit'(r[1]), e, $sformatf("rand%0d_dut%0d", r, idx));
    end

    // Abort a block around round 30, then confirm the chain restarted from the IV.
    rand_block(rb);
    @(negedge clk);
    bv[0] = 1'b1; bd[0] = rb; bf[0] = 1'b0;
    @(posedge clk);
    #1 bv[0] = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (dv[0]) pulses++;
    check("abort_rst_ready", br[0], 1);
    check("abort_rst_busy", bz[0], 0);
    check("abort_rst_digest", dg[0], 0);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (dv[0]) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    for (int i = 0; i < N_DUT; i++) chain[i] = iv_of(i);
    e = model_step(0, abc, 1'b0);
    run_block(0, abc, 1'b0, 1'b0, ABC256, "abort_then_abc");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
